// File: rtl/param_register_file.sv
// Parametrised dual-read, single-write register file.
// - Configurable data width and depth.
// - Optional hard-wired zero register and optional write-to-read bypass.
// - After reset, or on a clear request, a sweep engine zeroes the array one
//   entry per clock. busy is high while the sweep runs.
module param_register_file #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 4,
   parameter int ZERO_REG   = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] reg_to_write,
   input  logic [DATA_WIDTH-1:0] data_to_write,
   input  logic [ADDR_WIDTH-1:0] reg_to_read1,
   input  logic [ADDR_WIDTH-1:0] reg_to_read2,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] data_to_read1,
   output logic [DATA_WIDTH-1:0] data_to_read2,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   logic [0:0]            state_r;
   logic [0:0]            state_next_s;
   logic [ADDR_WIDTH-1:0] count_r;
   logic [ADDR_WIDTH-1:0] count_next_s;
   logic                  busy_r;
   logic [DATA_WIDTH-1:0] rd1_r;
   logic [DATA_WIDTH-1:0] rd2_r;
   logic [DATA_WIDTH-1:0] rd1_next_s;
   logic [DATA_WIDTH-1:0] rd2_next_s;

   logic                  wr_en_s;
   logic [ADDR_WIDTH-1:0] wr_idx_s;
   logic [DATA_WIDTH-1:0] wr_data_s;
   logic                  wr_drop_zero_s;
   logic                  wr_hit_s;

   // Read data for one port in normal operation.
   // The zero register takes priority over the bypass path.
   // A dropped write to register 0 never bypasses.
   function automatic logic [DATA_WIDTH-1:0] resolve_read(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic [DATA_WIDTH-1:0] stored,
      input logic                  write_live,
      input logic [ADDR_WIDTH-1:0] write_idx,
      input logic [DATA_WIDTH-1:0] write_data
   );
      logic [DATA_WIDTH-1:0] val;
      if ((ZERO_REG != 0) && (idx == ZERO_IDX)) begin
         val = ZERO_DATA;
      end else if ((BYPASS != 0) && write_live && (idx == write_idx)) begin
         val = write_data;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // Qualify the write strobe: writes to register 0 vanish when it is hard-wired.
   always_comb begin
      wr_drop_zero_s = (ZERO_REG != 0) && (reg_to_write == ZERO_IDX);
      wr_hit_s       = load && !wr_drop_zero_s;
   end

   // Next-state, array write port and read-data selection.
   always_comb begin
      state_next_s = state_r;
      count_next_s = count_r;
      wr_en_s      = 1'b0;
      wr_idx_s     = count_r;
      wr_data_s    = ZERO_DATA;
      rd1_next_s   = rd1_r;
      rd2_next_s   = rd2_r;
      case (state_r)
         ST_CLEAR: begin
            // Zero one entry per clock; all requests are ignored.
            wr_en_s    = 1'b1;
            wr_idx_s   = count_r;
            wr_data_s  = ZERO_DATA;
            rd1_next_s = ZERO_DATA;
            rd2_next_s = ZERO_DATA;
            if (count_r == LAST_IDX) begin
               state_next_s = ST_IDLE;
               count_next_s = ZERO_IDX;
            end else begin
               count_next_s = count_r + ADDR_WIDTH'(1'b1);
            end
         end
         ST_IDLE: begin
            if (clear) begin
               // Start a sweep. Any same-cycle write is dropped and the read outputs hold.
               state_next_s = ST_CLEAR;
               count_next_s = ZERO_IDX;
            end else if (enable) begin
               wr_en_s    = wr_hit_s;
               wr_idx_s   = reg_to_write;
               wr_data_s  = data_to_write;
               rd1_next_s = resolve_read(reg_to_read1, mem_r[reg_to_read1],
                                         wr_hit_s, reg_to_write, data_to_write);
               rd2_next_s = resolve_read(reg_to_read2, mem_r[reg_to_read2],
                                         wr_hit_s, reg_to_write, data_to_write);
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_CLEAR;
            count_next_s = ZERO_IDX;
         end
      endcase
   end

   // Storage array: no reset of its own; the sweep engine zeroes it.
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_CLEAR;
         count_r <= ZERO_IDX;
         busy_r  <= 1'b1;
         rd1_r   <= ZERO_DATA;
         rd2_r   <= ZERO_DATA;
      end else begin
         state_r <= state_next_s;
         count_r <= count_next_s;
         busy_r  <= (state_next_s == ST_CLEAR);
         rd1_r   <= rd1_next_s;
         rd2_r   <= rd2_next_s;
      end
   end

   assign data_to_read1 = rd1_r;
   assign data_to_read2 = rd2_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file.
// Three instances share one stimulus stream:
//   dut0: defaults (bypass on, no zero register)
//   dut1: bypass off
//   dut2: hard-wired zero register
module tb_param_register_file;

   localparam int DW    = 18;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic          load;
   logic          clear;
   logic [AW-1:0] reg_to_write;
   logic [AW-1:0] rd_a1;
   logic [AW-1:0] rd_a2;
   logic [DW-1:0] wdata;

   logic [DW-1:0] q1 [3];
   logic [DW-1:0] q2 [3];
   logic          bsy [3];

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(1)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .reg_to_write(reg_to_write), .data_to_write(wdata),
      .reg_to_read1(rd_a1), .reg_to_read2(rd_a2), .clear(clear),
      .data_to_read1(q1[0]), .data_to_read2(q2[0]), .busy(bsy[0]));

   param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0)) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .reg_to_write(reg_to_write), .data_to_write(wdata),
      .reg_to_read1(rd_a1), .reg_to_read2(rd_a2), .clear(clear),
      .data_to_read1(q1[1]), .data_to_read2(q2[1]), .busy(bsy[1]));

   param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut2 (
      .clock(clock), .reset(reset), .enable(enable), .load(load),
      .reg_to_write(reg_to_write), .data_to_write(wdata),
      .reg_to_read1(rd_a1), .reg_to_read2(rd_a2), .clear(clear),
      .data_to_read1(q1[2]), .data_to_read2(q2[2]), .busy(bsy[2]));

   // Reference model: register contents, remaining sweep edges, expected outputs.
   logic [DW-1:0] m_mem [3][DEPTH];
   int            m_left [3];
   logic [DW-1:0] m_o1 [3];
   logic [DW-1:0] m_o2 [3];

   function automatic bit has_zero(input int k);
      return (k == 2);
   endfunction

   function automatic bit has_bypass(input int k);
      return (k != 1);
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] idx, input bit wr);
      if (has_zero(k) && idx == 4'd0) return 18'h0;
      if (has_bypass(k) && wr && idx == reg_to_write) return wdata;
      return m_mem[k][idx];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_left[k] = DEPTH;
         m_o1[k]   = 18'h0;
         m_o2[k]   = 18'h0;
      end
   endtask

   task automatic model_step();
      bit wr;
      for (int k = 0; k < 3; k++) begin
         if (m_left[k] > 0) begin
            m_mem[k][DEPTH - m_left[k]] = 18'h0;
            m_left[k] = m_left[k] - 1;
            m_o1[k]   = 18'h0;
            m_o2[k]   = 18'h0;
         end else if (clear) begin
            m_left[k] = DEPTH;
         end else if (enable) begin
            wr = load && !(has_zero(k) && reg_to_write == 4'd0);
            m_o1[k] = model_read(k, rd_a1, wr);
            m_o2[k] = model_read(k, rd_a2, wr);
            if (wr) m_mem[k][reg_to_write] = wdata;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         check("busy", k, {31'd0, bsy[k]}, {31'd0, (m_left[k] > 0)});
         check("read1", k, {14'd0, q1[k]}, {14'd0, m_o1[k]});
         check("read2", k, {14'd0, q2[k]}, {14'd0, m_o2[k]});
      end
   endtask

   task automatic do_cycle(input logic en, input logic ld, input logic [AW-1:0] wa,
                           input logic [DW-1:0] d, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic cl);
      enable = en; load = ld; reg_to_write = wa; wdata = d;
      rd_a1 = a1; rd_a2 = a2; clear = cl;
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   // Run idle cycles while busy (bounded) and return how many edges busy stayed high.
   task automatic count_sweep(input int clear_at, output int n);
      n = 0;
      while (bsy[0] === 1'b1 && n < 40) begin
         do_cycle(1'b0, 1'b0, 4'd0, 18'h0, 4'd0, 4'd0, (n == clear_at) ? 1'b1 : 1'b0);
         n++;
      end
   endtask

   typedef struct {
      logic          en;
      logic          ld;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [DW-1:0] e1_byp;
      logic [DW-1:0] e1_nobyp;
      logic [DW-1:0] e1_zero;
      logic [DW-1:0] e2_byp;
   } vec_t;

   vec_t tbl [8];
   int   n;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 4'd5, 18'h2ABCD, 4'd0, 4'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
      tbl[1] = '{1'b1, 1'b0, 4'd0, 18'h00000, 4'd5, 4'd5, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD};
      tbl[2] = '{1'b0, 1'b0, 4'd0, 18'h00000, 4'd1, 4'd2, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD, 18'h2ABCD};
      tbl[3] = '{1'b1, 1'b1, 4'd3, 18'h00011, 4'd0, 4'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
      tbl[4] = '{1'b1, 1'b1, 4'd3, 18'h12345, 4'd3, 4'd5, 18'h12345, 18'h00011, 18'h12345, 18'h2ABCD};
      tbl[5] = '{1'b1, 1'b0, 4'd0, 18'h00000, 4'd3, 4'd3, 18'h12345, 18'h12345, 18'h12345, 18'h12345};
      tbl[6] = '{1'b1, 1'b1, 4'd0, 18'h3FFFF, 4'd0, 4'd15, 18'h3FFFF, 18'h00000, 18'h00000, 18'h00000};
      tbl[7] = '{1'b1, 1'b0, 4'd0, 18'h00000, 4'd0, 4'd0, 18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h3FFFF};

      // Reset and initial sweep
      reset = 1'b1; enable = 1'b0; load = 1'b0; clear = 1'b0;
      reg_to_write = 4'd0; wdata = 18'h0; rd_a1 = 4'd0; rd_a2 = 4'd0;
      #12;
      model_reset();
      #1;
      compare_all();
      reset = 1'b0;
      count_sweep(-1, n);
      check("reset_sweep_len", 0, n, 16);

      // Every register reads zero after the sweep
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle(1'b1, 1'b0, 4'd0, 18'h0, 4'(i), 4'(15 - i), 1'b0);
         check("post_sweep_zero", 0, {14'd0, q1[0]}, 32'd0);
      end

      // Directed vectors: write/read, hold, bypass, register 0
      for (int i = 0; i < 8; i++) begin
         do_cycle(tbl[i].en, tbl[i].ld, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2, 1'b0);
         check("vec_rd1_bypass", i, {14'd0, q1[0]}, {14'd0, tbl[i].e1_byp});
         check("vec_rd1_nobypass", i, {14'd0, q1[1]}, {14'd0, tbl[i].e1_nobyp});
         check("vec_rd1_zeroreg", i, {14'd0, q1[2]}, {14'd0, tbl[i].e1_zero});
         check("vec_rd2_bypass", i, {14'd0, q2[0]}, {14'd0, tbl[i].e2_byp});
      end

      // Clear mid-operation: same-cycle write dropped, second clear ignored
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle(1'b1, 1'b1, 4'(i), DW'($urandom) | 18'h1, 4'd0, 4'd0, 1'b0);
      end
      do_cycle(1'b1, 1'b1, 4'd7, 18'h15555, 4'd7, 4'd7, 1'b0);
      do_cycle(1'b1, 1'b1, 4'd7, 18'h2AAAA, 4'd7, 4'd7, 1'b1);
      check("clear_busy_rise", 0, {31'd0, bsy[0]}, 32'd1);
      count_sweep(4, n);
      check("clear_sweep_len", 0, n, 16);
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle(1'b1, 1'b0, 4'd0, 18'h0, 4'(i), 4'd7, 1'b0);
         check("clear_zero_rd1", 0, {14'd0, q1[0]}, 32'd0);
         check("clear_zero_reg7", 0, {14'd0, q2[0]}, 32'd0);
      end

      // Randomised traffic against the model
      for (int c = 0; c < 400; c++) begin
         logic [AW-1:0] wa;
         wa = AW'($urandom);
         do_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  wa,
                  DW'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom),
                  ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end

      // Asynchronous reset while outputs are non-zero
      count_sweep(-1, n);
      do_cycle(1'b1, 1'b1, 4'd9, 18'h3C3C3, 4'd0, 4'd0, 1'b0);
      do_cycle(1'b1, 1'b0, 4'd0, 18'h0, 4'd9, 4'd9, 1'b0);
      check("preset_value", 0, {14'd0, q1[0]}, 32'h3C3C3);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      #2;
      reset = 1'b0;

      // Reset eight cycles into a sweep restarts a full sweep
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b0, 1'b0, 4'd0, 18'h0, 4'd0, 4'd0, 1'b0);
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      #2;
      reset = 1'b0;
      count_sweep(-1, n);
      check("midsweep_reset_len", 0, n, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
